// File: rtl/iterative_shifter_if.sv
// Request/response handshake bundle for iterative_shifter.
// The master side issues shift requests and consumes results.
interface iterative_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR by a variable amount, at most STEP bits per clock.
// One operation in flight; all handshake outputs come straight from flops.
module iterative_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    iterative_shifter_if.slave  bus,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [SHAMT_W-1:0] step_k;
    logic [1:0]         op_q, op_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;

    // One partial shift. SRA keeps the MSB at each step, so the original sign persists.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0]   d,
        input logic [SHAMT_W-1:0] k,
        input logic [1:0]         op
    );
        logic signed [WIDTH-1:0] sd;
        logic [2*WIDTH-1:0]      rot;
        sd  = $signed(d);
        rot = {d, d} >> k;
        case (op)
            OP_SLL:  shift_step = d << k;
            OP_SRL:  shift_step = d >> k;
            OP_SRA:  shift_step = sd >>> k;
            default: shift_step = rot[WIDTH-1:0];
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        op_d    = op_q;
        step_k  = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    data_d  = bus.in_data;
                    rem_d   = bus.in_shamt;
                    op_d    = bus.in_op;
                    state_d = (bus.in_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = shift_step(data_q, step_k, op_q);
                rem_d  = rem_q - step_k;
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        out_data_d  = (state_d == DONE) ? data_d : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            op_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: directed cases on a STEP=2 instance, then
// randomised traffic on STEP=1/3/8 instances against a behavioural model.
module tb_iterative_shifter;
    logic clock = 1'b0;
    logic reset_n;
    logic busy0;
    logic [2:0] go;
    logic [2:0] done;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    iterative_shifter_if #(.WIDTH(32), .SHAMT_W(5)) if0 ();
    iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(2)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .bus(if0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Result of a single shift by s, straight from the operator definitions.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] op);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return (d >> s) | (d << (32 - s));
        endcase
    endfunction

    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        int guard = 0;
        while (!if0.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("send_ready", 32'(if0.in_ready), 32'(1));
        if0.in_valid = 1'b1;
        if0.in_data  = d;
        if0.in_shamt = s;
        if0.in_op    = op;
        tick();
        if0.in_valid = 1'b0;
        if0.in_data  = ~d;
        if0.in_shamt = ~s;
    endtask

    task automatic await_result(input string tag, input logic [31:0] exp, input int exp_lat);
        int lat = 1;
        bit rdy_seen = 1'b0;
        bit busy_lo  = 1'b0;
        while (!if0.out_valid && lat < 100) begin
            if (if0.in_ready) rdy_seen = 1'b1;
            if (!busy0) busy_lo = 1'b1;
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, if0.out_data, exp);
        check({tag, "_inrdy"}, 32'(rdy_seen | if0.in_ready), 32'(0));
        check({tag, "_busy"}, 32'(!busy_lo && busy0), 32'(1));
    endtask

    task automatic drain(input string tag);
        if0.out_ready = 1'b1;
        tick();
        if0.out_ready = 1'b0;
        check({tag, "_vld_drop"}, 32'(if0.out_valid), 32'(0));
        check({tag, "_data_zero"}, if0.out_data, 32'h0);
        check({tag, "_idle_rdy"}, 32'(if0.in_ready), 32'(1));
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int ST = (g == 0) ? 1 : ((g == 1) ? 3 : 8);
        iterative_shifter_if #(.WIDTH(32), .SHAMT_W(5)) rif ();
        logic rbusy;
        iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(ST)) u_dut (
            .clock(clock), .reset_n(reset_n), .bus(rif), .busy(rbusy)
        );

        initial begin
            logic [31:0] d;
            logic [31:0] exp;
            logic [4:0]  s;
            logic [1:0]  op;
            int lat;
            int hold;
            rif.in_valid  = 1'b0;
            rif.in_data   = '0;
            rif.in_shamt  = '0;
            rif.in_op     = '0;
            rif.out_ready = 1'b0;
            done[g]       = 1'b0;
            wait (go[g]);
            tick();
            for (int n = 0; n < 40; n++) begin
                d   = $urandom;
                s   = 5'($urandom_range(31, 0));
                op  = 2'($urandom_range(3, 0));
                exp = ref_shift(d, int'(s), op);
                check($sformatf("s%0d_ready", ST), 32'(rif.in_ready), 32'(1));
                rif.in_valid = 1'b1;
                rif.in_data  = d;
                rif.in_shamt = s;
                rif.in_op    = op;
                tick();
                rif.in_valid = 1'b0;
                rif.in_data  = $urandom;
                rif.in_op    = 2'($urandom_range(3, 0));
                lat = 1;
                while (!rif.out_valid && lat < 64) begin
                    tick();
                    lat++;
                end
                check($sformatf("s%0d_lat op%0d sh%0d", ST, op, s), 32'(lat),
                      32'(1 + (int'(s) + ST - 1) / ST));
                check($sformatf("s%0d_data op%0d sh%0d d%08h", ST, op, s, d), rif.out_data, exp);
                hold = $urandom_range(2, 0);
                repeat (hold) tick();
                check($sformatf("s%0d_hold", ST), rif.out_data, exp);
                rif.out_ready = 1'b1;
                tick();
                rif.out_ready = 1'b0;
                check($sformatf("s%0d_drop", ST), 32'(rif.out_valid), 32'(0));
            end
            done[g] = 1'b1;
        end
    end

    initial begin
        logic [31:0] held;
        bit seen;
        int guard;
        reset_n       = 1'b0;
        go            = '0;
        if0.in_valid  = 1'b0;
        if0.in_data   = '0;
        if0.in_shamt  = '0;
        if0.in_op     = '0;
        if0.out_ready = 1'b0;
        repeat (2) tick();
        check("rst_in_ready", 32'(if0.in_ready), 32'(1));
        check("rst_out_valid", 32'(if0.out_valid), 32'(0));
        check("rst_out_data", if0.out_data, 32'h0);
        check("rst_busy", 32'(busy0), 32'(0));
        reset_n = 1'b1;
        tick();

        send(32'h8000_0010, 5'd2, 2'b10);
        await_result("sra2", 32'hE000_0004, 2);
        drain("sra2");

        send(32'h8000_0000, 5'd31, 2'b01);
        await_result("srl31", 32'h0000_0001, 17);
        drain("srl31");

        send(32'h1234_5678, 5'd0, 2'b00);
        await_result("sll0", 32'h1234_5678, 1);
        drain("sll0");

        send(32'h0000_000F, 5'd4, 2'b11);
        await_result("ror4", 32'hF000_0000, 3);
        drain("ror4");

        send(32'h7FFF_FFFF, 5'd31, 2'b10);
        await_result("sra31", 32'h0000_0000, 17);
        drain("sra31");

        // Backpressure: result must hold and no new request may slip in.
        send(32'h0000_0001, 5'd3, 2'b00);
        await_result("bp", 32'h0000_0008, 3);
        held = if0.out_data;
        if0.in_valid = 1'b1;
        if0.in_shamt = 5'd0;
        if0.in_op    = 2'b00;
        for (int i = 0; i < 5; i++) begin
            if0.in_data = $urandom;
            tick();
            check("bp_stable", if0.out_data, held);
            check("bp_inrdy", 32'(if0.in_ready), 32'(0));
        end
        if0.in_data   = 32'hA5A5_A5A5;
        if0.out_ready = 1'b1;
        tick();
        if0.out_ready = 1'b0;
        check("bp_idle_vld", 32'(if0.out_valid), 32'(0));
        check("bp_idle_rdy", 32'(if0.in_ready), 32'(1));
        tick();
        if0.in_valid = 1'b0;
        check("bp_next_vld", 32'(if0.out_valid), 32'(1));
        check("bp_next_data", if0.out_data, 32'hA5A5_A5A5);
        drain("bp_next");

        // Abort a long SRL with reset partway through.
        send(32'hFFFF_0000, 5'd20, 2'b01);
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        check("abort_in_ready", 32'(if0.in_ready), 32'(1));
        check("abort_out_valid", 32'(if0.out_valid), 32'(0));
        check("abort_out_data", if0.out_data, 32'h0);
        check("abort_busy", 32'(busy0), 32'(0));
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (if0.out_valid || busy0) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'(0));

        send(32'hC000_0003, 5'd1, 2'b11);
        await_result("ror1", 32'hE000_0001, 2);
        drain("ror1");

        for (int g = 0; g < 3; g++) begin
            go[g] = 1'b1;
            guard = 0;
            while (!done[g] && guard < 20000) begin
                tick();
                guard++;
            end
            check($sformatf("rand%0d_done", g), 32'(done[g]), 32'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
